// File: rtl/fifo_sync_thresh_pkg.sv
// rtl/fifo_sync_thresh_pkg.sv - shared width helpers for the single-clock FIFO
package fifo_sync_thresh_pkg;

    // Ceil-log2 with a floor of one bit, so DEPTH=1 still gets a usable vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_wrap_ctr.sv
// rtl/fifo_wrap_ctr.sv - enable-gated counter wrapping MAX-1 to 0 with sync clear
module fifo_wrap_ctr
    import fifo_sync_thresh_pkg::*;
#(
    parameter int MAX = 8,
    parameter int W   = clog2_min1(MAX)
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] value_o
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            value_o <= '0;
        end else if (en_i) begin
            value_o <= (value_o == LAST) ? '0 : value_o + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_sync_thresh.sv
// rtl/fifo_sync_thresh.sv - single-clock valid/ready FIFO with usage and threshold flags
module fifo_sync_thresh
    import fifo_sync_thresh_pkg::*;
#(
    parameter int  WIDTH           = 32,
    parameter type T               = logic [WIDTH-1:0],
    parameter int  DEPTH           = 8,
    parameter bit  FALL_THROUGH    = 1'b0,
    parameter int  ALMOST_FULL_TH  = DEPTH - 1,
    parameter int  ALMOST_EMPTY_TH = 1,
    parameter int  CNT_W           = clog2_min1(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  T                 src_data_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    output T                 dst_data_o,
    output logic             dst_valid_o,
    input  logic             dst_ready_i,
    output logic [CNT_W-1:0] usage_o,
    output logic             almost_full_o,
    output logic             almost_empty_o
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(ALMOST_EMPTY_TH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("fifo_sync_thresh: DEPTH must be >= 1");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
        $error("fifo_sync_thresh: ALMOST_FULL_TH must be in 1..DEPTH");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH >= DEPTH) begin : g_bad_ae
        $error("fifo_sync_thresh: ALMOST_EMPTY_TH must be in 0..DEPTH-1");
    end

    T                 mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             clr;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;

    assign clr   = rst_i | flush_i;
    assign empty = (count == '0);

    assign src_ready_o = (count != FULL_C) & ~flush_i & ~rst_i;
    assign dst_valid_o = ~flush_i & ~rst_i & (~empty | (FALL_THROUGH & src_valid_i));
    assign dst_data_o  = (FALL_THROUGH && empty) ? src_data_i : mem[rptr];

    assign push = src_valid_i & src_ready_o;
    assign pop  = dst_valid_o & dst_ready_i;

    // A word passing straight through an empty fall-through FIFO never touches storage.
    assign bypass = FALL_THROUGH & empty & push & pop;
    assign wr_en  = push & ~bypass;
    assign rd_en  = pop & ~bypass;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr] <= src_data_i;
        end
    end

    fifo_wrap_ctr #(.MAX(DEPTH), .W(PTR_W)) u_wptr (
        .clk_i   (clk_i),
        .clr_i   (clr),
        .en_i    (wr_en),
        .value_o (wptr)
    );

    fifo_wrap_ctr #(.MAX(DEPTH), .W(PTR_W)) u_rptr (
        .clk_i   (clk_i),
        .clr_i   (clr),
        .en_i    (rd_en),
        .value_o (rptr)
    );

    always_ff @(posedge clk_i) begin
        if (clr) begin
            count <= '0;
        end else if (wr_en && !rd_en) begin
            count <= count + 1'b1;
        end else if (rd_en && !wr_en) begin
            count <= count - 1'b1;
        end
    end

    assign usage_o        = count;
    assign almost_full_o  = (count >= AF_C);
    assign almost_empty_o = (count <= AE_C);

    a_src_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (src_valid_i && !src_ready_o && !flush_i) |=> (src_valid_i && $stable(src_data_i)))
        else $error("fifo_sync_thresh: source dropped or changed a stalled word");

    a_count_max: assert property (@(posedge clk_i) disable iff (rst_i) (count <= FULL_C))
        else $error("fifo_sync_thresh: count exceeded DEPTH");

endmodule

// File: tb/tb_fifo_sync_thresh.sv
// tb/tb_fifo_sync_thresh.sv - directed bench for fifo_sync_thresh, registered and fall-through
module tb_fifo_sync_thresh;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       flush0 = 1'b0, sv0 = 1'b0, dr0 = 1'b0;
    logic [7:0] sd0 = 8'h00;
    logic       srdy0, dv0, af0, ae0;
    logic [7:0] dd0;
    logic [2:0] use0;

    logic       flush1 = 1'b0, sv1 = 1'b0, dr1 = 1'b0;
    logic [7:0] sd1 = 8'h00;
    logic       srdy1, dv1, af1, ae1;
    logic [7:0] dd1;
    logic [2:0] use1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_sync_thresh #(.WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b0),
                       .ALMOST_FULL_TH(4), .ALMOST_EMPTY_TH(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush0),
        .src_data_i(sd0), .src_valid_i(sv0), .src_ready_o(srdy0),
        .dst_data_o(dd0), .dst_valid_o(dv0), .dst_ready_i(dr0),
        .usage_o(use0), .almost_full_o(af0), .almost_empty_o(ae0)
    );

    fifo_sync_thresh #(.WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b1),
                       .ALMOST_FULL_TH(4), .ALMOST_EMPTY_TH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush1),
        .src_data_i(sd1), .src_valid_i(sv1), .src_ready_o(srdy1),
        .dst_data_o(dd1), .dst_valid_o(dv1), .dst_ready_i(dr1),
        .usage_o(use1), .almost_full_o(af1), .almost_empty_o(ae1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (use0 !== 3'd0) begin n_bad++; $display("FAIL reset_usage got %0d want 0", use0); end
        n_vec++; if (ae0 !== 1'b1) begin n_bad++; $display("FAIL reset_ae got %b want 1", ae0); end
        n_vec++; if (af0 !== 1'b0) begin n_bad++; $display("FAIL reset_af got %b want 0", af0); end
        n_vec++; if (srdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", srdy0); end
        n_vec++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dv0); end
        n_vec++; if (dv1 !== 1'b0) begin n_bad++; $display("FAIL reset_ft_valid got %b want 0", dv1); end
    endtask

    task automatic test_fill;
        dr0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sv0 = 1'b1;
            sd0 = 8'h11 + 8'(i);
            #1;
            n_vec++; if (srdy0 !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d] got %b want 1", i, srdy0); end
            tick();
            n_vec++; if (use0 !== 3'(i + 1)) begin n_bad++; $display("FAIL fill_usage[%0d] got %0d want %0d", i, use0, i + 1); end
            n_vec++; if (af0 !== (i + 1 >= 4)) begin n_bad++; $display("FAIL fill_af[%0d] got %b want %b", i, af0, (i + 1 >= 4)); end
            n_vec++; if (ae0 !== (i + 1 <= 1)) begin n_bad++; $display("FAIL fill_ae[%0d] got %b want %b", i, ae0, (i + 1 <= 1)); end
        end
        sv0 = 1'b0;
        #1;
        n_vec++; if (srdy0 !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", srdy0); end
        n_vec++; if (dv0 !== 1'b1 || dd0 !== 8'h11) begin n_bad++; $display("FAIL full_head got %b/%h want 1/11", dv0, dd0); end
    endtask

    task automatic test_drain;
        dr0 = 1'b1;
        sv0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (dv0 !== 1'b1 || dd0 !== 8'h11 + 8'(i)) begin n_bad++; $display("FAIL drain[%0d] got %b/%h want 1/%h", i, dv0, dd0, 8'h11 + 8'(i)); end
            tick();
        end
        n_vec++; if (dv0 !== 1'b0 || use0 !== 3'd0) begin n_bad++; $display("FAIL drain_end got %b/%0d want 0/0", dv0, use0); end
    endtask

    task automatic test_wrap_stream;
        dr0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sv0 = (k < 7);
            sd0 = 8'h21 + 8'(k);
            #1;
            if (k >= 1) begin
                n_vec++; if (dv0 !== 1'b1 || dd0 !== 8'h20 + 8'(k)) begin n_bad++; $display("FAIL wrap_data[%0d] got %b/%h want 1/%h", k, dv0, dd0, 8'h20 + 8'(k)); end
            end
            tick();
            n_vec++; if (use0 !== ((k < 7) ? 3'd1 : 3'd0)) begin n_bad++; $display("FAIL wrap_usage[%0d] got %0d want %0d", k, use0, (k < 7) ? 1 : 0); end
        end
        sv0 = 1'b0;
    endtask

    task automatic test_back_to_back;
        dr0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sv0 = 1'b1;
            sd0 = 8'h31 + 8'(i);
            tick();
        end
        n_vec++; if (use0 !== 3'd5) begin n_bad++; $display("FAIL b2b_full got %0d want 5", use0); end
        dr0 = 1'b1;
        sd0 = 8'h36;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (srdy0 !== (c != 0)) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want %b", c, srdy0, (c != 0)); end
            n_vec++; if (dv0 !== 1'b1 || dd0 !== 8'h31 + 8'(c)) begin n_bad++; $display("FAIL b2b_pop[%0d] got %b/%h want 1/%h", c, dv0, dd0, 8'h31 + 8'(c)); end
            tick();
            n_vec++; if (use0 !== 3'd4) begin n_bad++; $display("FAIL b2b_usage[%0d] got %0d want 4", c, use0); end
            if (c >= 1) sd0 = 8'h37;
        end
        sv0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (dv0 !== 1'b1 || dd0 !== 8'h34 + 8'(i)) begin n_bad++; $display("FAIL b2b_drain[%0d] got %b/%h want 1/%h", i, dv0, dd0, 8'h34 + 8'(i)); end
            tick();
        end
        n_vec++; if (dv0 !== 1'b0 || use0 !== 3'd0) begin n_bad++; $display("FAIL b2b_empty got %b/%0d want 0/0", dv0, use0); end
    endtask

    task automatic test_fall_through;
        sv1 = 1'b1;
        sd1 = 8'hAA;
        dr1 = 1'b1;
        #1;
        n_vec++; if (dv1 !== 1'b1 || dd1 !== 8'hAA) begin n_bad++; $display("FAIL ft_bypass got %b/%h want 1/aa", dv1, dd1); end
        tick();
        n_vec++; if (use1 !== 3'd0) begin n_bad++; $display("FAIL ft_bypass_usage got %0d want 0", use1); end
        dr1 = 1'b0;
        sd1 = 8'hBB;
        #1;
        n_vec++; if (dv1 !== 1'b1 || dd1 !== 8'hBB) begin n_bad++; $display("FAIL ft_stall got %b/%h want 1/bb", dv1, dd1); end
        tick();
        sv1 = 1'b0;
        sd1 = 8'h00;
        #1;
        n_vec++; if (use1 !== 3'd1 || dv1 !== 1'b1 || dd1 !== 8'hBB) begin n_bad++; $display("FAIL ft_stored got %0d/%b/%h want 1/1/bb", use1, dv1, dd1); end
        dr1 = 1'b1;
        tick();
        n_vec++; if (use1 !== 3'd0 || dv1 !== 1'b0) begin n_bad++; $display("FAIL ft_drained got %0d/%b want 0/0", use1, dv1); end
        dr1 = 1'b0;
    endtask

    task automatic test_flush;
        dr0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sv0 = 1'b1;
            sd0 = 8'h51 + 8'(i);
            tick();
        end
        flush0 = 1'b1;
        sd0 = 8'h99;
        dr0 = 1'b1;
        #1;
        n_vec++; if (srdy0 !== 1'b0 || dv0 !== 1'b0) begin n_bad++; $display("FAIL flush_hs got %b/%b want 0/0", srdy0, dv0); end
        tick();
        flush0 = 1'b0;
        sv0 = 1'b0;
        dr0 = 1'b0;
        #1;
        n_vec++; if (use0 !== 3'd0 || dv0 !== 1'b0) begin n_bad++; $display("FAIL flush_after got %0d/%b want 0/0", use0, dv0); end
        sv0 = 1'b1;
        sd0 = 8'h42;
        tick();
        sv0 = 1'b0;
        #1;
        n_vec++; if (dv0 !== 1'b1 || dd0 !== 8'h42 || use0 !== 3'd1) begin n_bad++; $display("FAIL flush_next got %b/%h/%0d want 1/42/1", dv0, dd0, use0); end
        dr0 = 1'b1;
        tick();
        dr0 = 1'b0;
    endtask

    task automatic test_reset_mid;
        dr0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sv0 = 1'b1;
            sd0 = 8'h61 + 8'(i);
            tick();
        end
        sv0 = 1'b0;
        n_vec++; if (use0 !== 3'd4 || af0 !== 1'b1) begin n_bad++; $display("FAIL pre_reset got %0d/%b want 4/1", use0, af0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (use0 !== 3'd0 || ae0 !== 1'b1 || af0 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags got %0d/%b/%b want 0/1/0", use0, ae0, af0); end
        n_vec++; if (srdy0 !== 1'b1 || dv0 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_hs got %b/%b want 1/0", srdy0, dv0); end
        sv0 = 1'b1;
        sd0 = 8'h77;
        tick();
        sv0 = 1'b0;
        #1;
        n_vec++; if (dv0 !== 1'b1 || dd0 !== 8'h77) begin n_bad++; $display("FAIL mid_reset_next got %b/%h want 1/77", dv0, dd0); end
        dr0 = 1'b1;
        tick();
        dr0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap_stream();
        test_back_to_back();
        test_fall_through();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
